// File: rtl/xgriscv_mem_arbiter_pkg.sv
// Shared types and constants for the instruction/data memory arbiter.
package xgriscv_mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ArbIdle  = 2'd0,
    ArbIBusy = 2'd1,
    ArbDBusy = 2'd2
  } arb_state_e;

  localparam logic [3:0] AmpWord = 4'b1111;

  // Saturating increment of the consecutive-data-grant streak.
  function automatic int unsigned streak_next(input int unsigned cur, input int unsigned max);
    return (cur >= max) ? max : cur + 1;
  endfunction

endpackage

// File: rtl/xgriscv_mem_arbiter.sv
// Arbitrates the CPU fetch and data ports onto one single-port memory, one transaction
// at a time; data has priority, bounded by a streak limit so fetch always progresses.
module xgriscv_mem_arbiter
  import xgriscv_mem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_SIZE   = 32,
  parameter int unsigned XLEN        = 32,
  parameter int unsigned DSTREAK_MAX = 4,
  parameter int unsigned STREAK_W    = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_req,
  input  logic [ADDR_SIZE-1:0] i_addr,
  input  logic                 i_kill,
  output logic [XLEN-1:0]      i_rdata,
  output logic                 i_ready,
  input  logic                 d_req,
  input  logic                 d_we,
  input  logic [3:0]           d_amp,
  input  logic [ADDR_SIZE-1:0] d_addr,
  input  logic [XLEN-1:0]      d_wdata,
  output logic [XLEN-1:0]      d_rdata,
  output logic                 d_ready,
  output logic                 m_req,
  output logic                 m_we,
  output logic [3:0]           m_amp,
  output logic [ADDR_SIZE-1:0] m_addr,
  output logic [XLEN-1:0]      m_wdata,
  input  logic                 m_ack,
  input  logic [XLEN-1:0]      m_rdata
);

  arb_state_e           state_q, state_d;
  logic                 m_req_q, m_req_d;
  logic                 m_we_q, m_we_d;
  logic [3:0]           m_amp_q, m_amp_d;
  logic [ADDR_SIZE-1:0] m_addr_q, m_addr_d;
  logic [XLEN-1:0]      m_wdata_q, m_wdata_d;
  logic [XLEN-1:0]      i_rdata_q, i_rdata_d;
  logic [XLEN-1:0]      d_rdata_q, d_rdata_d;
  logic                 i_ready_q, i_ready_d;
  logic                 d_ready_q, d_ready_d;
  logic [STREAK_W-1:0]  streak_q, streak_d;
  logic                 kill_q, kill_d;

  logic i_req_ok;
  logic stale;
  logic streak_full;
  logic grant_d;

  assign i_req_ok    = i_req && !i_kill;
  // The ready cycle is dead: requests seen alongside a ready pulse are the old ones.
  assign stale       = i_ready_q || d_ready_q;
  assign streak_full = (streak_q == STREAK_W'(DSTREAK_MAX));
  assign grant_d     = d_req && !(i_req_ok && streak_full);

  always_comb begin
    state_d   = state_q;
    m_req_d   = m_req_q;
    m_we_d    = m_we_q;
    m_amp_d   = m_amp_q;
    m_addr_d  = m_addr_q;
    m_wdata_d = m_wdata_q;
    i_rdata_d = i_rdata_q;
    d_rdata_d = d_rdata_q;
    i_ready_d = 1'b0;
    d_ready_d = 1'b0;
    streak_d  = streak_q;
    kill_d    = kill_q;

    unique case (state_q)
      ArbIdle: begin
        kill_d = 1'b0;
        if (!d_req) begin
          streak_d = '0;
        end
        if (!stale) begin
          if (grant_d) begin
            state_d   = ArbDBusy;
            m_req_d   = 1'b1;
            m_we_d    = d_we;
            m_amp_d   = d_amp;
            m_addr_d  = d_addr;
            m_wdata_d = d_wdata;
            streak_d  = STREAK_W'(streak_next(32'(streak_q), DSTREAK_MAX));
          end else if (i_req_ok) begin
            state_d   = ArbIBusy;
            m_req_d   = 1'b1;
            m_we_d    = 1'b0;
            m_amp_d   = AmpWord;
            m_addr_d  = i_addr;
            m_wdata_d = '0;
            streak_d  = '0;
          end
        end
      end
      ArbIBusy: begin
        if (i_kill) begin
          kill_d = 1'b1;
        end
        if (m_ack) begin
          state_d = ArbIdle;
          m_req_d = 1'b0;
          kill_d  = 1'b0;
          // A redirect during the access discards the word without a ready pulse.
          if (!(kill_q || i_kill)) begin
            i_rdata_d = m_rdata;
            i_ready_d = 1'b1;
          end
        end
      end
      ArbDBusy: begin
        if (m_ack) begin
          state_d   = ArbIdle;
          m_req_d   = 1'b0;
          d_ready_d = 1'b1;
          if (!m_we_q) begin
            d_rdata_d = m_rdata;
          end
        end
      end
      default: begin
        state_d = ArbIdle;
        m_req_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ArbIdle;
      m_req_q   <= 1'b0;
      m_we_q    <= 1'b0;
      m_amp_q   <= '0;
      m_addr_q  <= '0;
      m_wdata_q <= '0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
      i_ready_q <= 1'b0;
      d_ready_q <= 1'b0;
      streak_q  <= '0;
      kill_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      m_req_q   <= m_req_d;
      m_we_q    <= m_we_d;
      m_amp_q   <= m_amp_d;
      m_addr_q  <= m_addr_d;
      m_wdata_q <= m_wdata_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
      i_ready_q <= i_ready_d;
      d_ready_q <= d_ready_d;
      streak_q  <= streak_d;
      kill_q    <= kill_d;
    end
  end

  assign m_req   = m_req_q;
  assign m_we    = m_we_q;
  assign m_amp   = m_amp_q;
  assign m_addr  = m_addr_q;
  assign m_wdata = m_wdata_q;
  assign i_rdata = i_rdata_q;
  assign i_ready = i_ready_q;
  assign d_rdata = d_rdata_q;
  assign d_ready = d_ready_q;

endmodule

// File: tb/tb_xgriscv_mem_arbiter.sv
// Self-checking bench for xgriscv_mem_arbiter: memory responder, per-port scoreboards
// and a word-array reference memory; fetches use 0x000-0x0FF, data uses 0x100-0x1FF.
module tb_xgriscv_mem_arbiter;

  typedef struct packed {
    logic        we;
    logic [3:0]  amp;
    logic [31:0] addr;
    logic [31:0] wdata;
  } txn_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_req, i_kill;
  logic [31:0] i_addr, i_rdata;
  logic        i_ready;
  logic        d_req, d_we;
  logic [3:0]  d_amp;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic        d_ready;
  logic        m_req, m_we;
  logic [3:0]  m_amp;
  logic [31:0] m_addr, m_wdata;
  logic        m_ack;
  logic [31:0] m_rdata;
  logic        ack_r, ack_spur;

  assign m_ack = ack_r | ack_spur;

  logic [31:0] mem     [128];
  logic [31:0] ref_mem [128];
  logic [31:0] i_exp[$];
  logic [31:0] d_exp[$];
  txn_t        txn_exp[$];
  bit          grant_log[$];  // 1 = data grant, 0 = fetch grant

  int checks = 0;
  int errors = 0;
  int grant_cnt = 0;
  int done_cnt = 0;
  int fixed_delay = 0;  // negative: random ack delay 0..3
  logic [31:0] last_fetch = '0;
  logic [31:0] last_load = '0;
  logic prev_i_ready = 1'b0;
  logic prev_d_ready = 1'b0;

  xgriscv_mem_arbiter #(
    .ADDR_SIZE  (32),
    .XLEN       (32),
    .DSTREAK_MAX(4),
    .STREAK_W   (3)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .i_req  (i_req),
    .i_addr (i_addr),
    .i_kill (i_kill),
    .i_rdata(i_rdata),
    .i_ready(i_ready),
    .d_req  (d_req),
    .d_we   (d_we),
    .d_amp  (d_amp),
    .d_addr (d_addr),
    .d_wdata(d_wdata),
    .d_rdata(d_rdata),
    .d_ready(d_ready),
    .m_req  (m_req),
    .m_we   (m_we),
    .m_amp  (m_amp),
    .m_addr (m_addr),
    .m_wdata(m_wdata),
    .m_ack  (m_ack),
    .m_rdata(m_rdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic fail(input string name, input logic [31:0] act);
    checks++;
    errors++;
    $display("FAIL %s: got 0x%08h, expected no such event", name, act);
  endtask

  // Memory: one access at a time, abandons the access if m_req drops (reset).
  initial begin
    txn_t te;
    int   dly;
    bit   gone;
    ack_r   = 1'b0;
    m_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      if (m_req && !reset) begin
        grant_cnt++;
        if (m_addr < 32'h100) begin
          grant_log.push_back(1'b0);
          check("fetch_m_we", 32'(m_we), 32'd0);
          check("fetch_m_amp", 32'(m_amp), 32'hF);
        end else begin
          grant_log.push_back(1'b1);
          if (txn_exp.size() == 0) begin
            fail("d_txn_unexpected", m_addr);
          end else begin
            te = txn_exp.pop_front();
            check("d_m_we", 32'(m_we), 32'(te.we));
            check("d_m_amp", 32'(m_amp), 32'(te.amp));
            check("d_m_addr", m_addr, te.addr);
            if (te.we) check("d_m_wdata", m_wdata, te.wdata);
          end
        end
        dly  = (fixed_delay >= 0) ? fixed_delay : int'($urandom_range(0, 3));
        gone = 1'b0;
        for (int k = 0; k < dly && !gone; k++) begin
          @(posedge clk);
          #1;
          if (!m_req) gone = 1'b1;
        end
        if (!gone) begin
          if (m_we) begin
            for (int b = 0; b < 4; b++)
              if (m_amp[b]) mem[m_addr[8:2]][8*b +: 8] = m_wdata[8*b +: 8];
          end else begin
            m_rdata = mem[m_addr[8:2]];
          end
          ack_r = 1'b1;
          @(posedge clk);
          #1;
          ack_r   = 1'b0;
          m_rdata = $urandom;
          done_cnt++;
        end
      end
    end
  end

  // Monitor: every ready pulse must match the oldest expectation of its port.
  always @(negedge clk) begin
    if (!reset) begin
      if (i_ready) begin
        check("i_ready_width", 32'(prev_i_ready), 32'd0);
        if (i_exp.size() == 0) fail("i_ready_unexpected", i_rdata);
        else check("i_rdata", i_rdata, i_exp.pop_front());
      end
      if (d_ready) begin
        check("d_ready_width", 32'(prev_d_ready), 32'd0);
        if (d_exp.size() == 0) fail("d_ready_unexpected", d_rdata);
        else check("d_rdata", d_rdata, d_exp.pop_front());
      end
    end
    prev_i_ready <= i_ready;
    prev_d_ready <= d_ready;
  end

  task automatic do_fetch(input logic [31:0] a, input bit hold, output int lat);
    int n;
    i_exp.push_back(ref_mem[a[8:2]]);
    last_fetch = ref_mem[a[8:2]];
    i_addr = a;
    i_req  = 1'b1;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!i_ready && n < 60);
    if (!i_ready) fail("i_timeout", 32'(n));
    if (hold) begin
      @(posedge clk);
      #1;
    end
    i_req = 1'b0;
    lat = n;
  endtask

  task automatic data_txn(input logic we, input logic [3:0] amp, input logic [31:0] a,
                          input logic [31:0] wd, input bit keep);
    int         n;
    logic [6:0] w;
    txn_t       t;
    w = a[8:2];
    t.we = we;
    t.amp = amp;
    t.addr = a;
    t.wdata = wd;
    txn_exp.push_back(t);
    if (we) begin
      for (int b = 0; b < 4; b++) if (amp[b]) ref_mem[w][8*b +: 8] = wd[8*b +: 8];
    end else begin
      last_load = ref_mem[w];
    end
    d_exp.push_back(last_load);
    d_we    = we;
    d_amp   = amp;
    d_addr  = a;
    d_wdata = wd;
    d_req   = 1'b1;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!d_ready && n < 60);
    if (!d_ready) fail("d_timeout", 32'(n));
    if (!keep) d_req = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, lat2, g0, d0;
    bit exp_order[7];
    logic [3:0] amps[5];
    txn_t t;
    exp_order = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    amps = '{4'b1111, 4'b0011, 4'b1100, 4'b0001, 4'b1000};

    reset = 1'b1; i_req = 1'b1; i_kill = 1'b0; i_addr = 32'h40;
    d_req = 1'b1; d_we = 1'b1; d_amp = 4'hF; d_addr = 32'h100; d_wdata = 32'h1234;
    ack_spur = 1'b0;
    for (int i = 0; i < 128; i++) begin
      mem[i] = $urandom;
      ref_mem[i] = mem[i];
    end
    mem[16] = 32'h0050_0093;
    ref_mem[16] = 32'h0050_0093;

    // Reset with requests pending
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_m_req", 32'(m_req), 32'd0);
    check("rst_m_we", 32'(m_we), 32'd0);
    check("rst_i_ready", 32'(i_ready), 32'd0);
    check("rst_d_ready", 32'(d_ready), 32'd0);
    check("rst_m_amp", 32'(m_amp), 32'd0);
    check("rst_m_addr", m_addr, 32'd0);
    check("rst_m_wdata", m_wdata, 32'd0);
    check("rst_i_rdata", i_rdata, 32'd0);
    check("rst_d_rdata", d_rdata, 32'd0);
    i_req = 1'b0;
    d_req = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Fetch only: ready two cycles after the request
    do_fetch(32'h40, 1'b0, lat);
    check("fetch_latency", 32'(lat), 32'd2);

    // Collision: data first, then fetch
    grant_log.delete();
    @(posedge clk);
    #1;
    fork
      data_txn(1'b1, 4'b0011, 32'h100, 32'hDEAD_BEEF, 1'b0);
      do_fetch(32'h44, 1'b0, lat);
    join
    check("coll_len", 32'(grant_log.size()), 32'd2);
    if (grant_log.size() >= 2) begin
      check("coll_first", 32'(grant_log[0]), 32'd1);
      check("coll_second", 32'(grant_log[1]), 32'd0);
    end
    data_txn(1'b0, 4'hF, 32'h100, 32'h0, 1'b0);

    // Starvation limit with back-to-back stores
    grant_log.delete();
    @(posedge clk);
    #1;
    fork
      begin
        for (int k = 0; k < 6; k++)
          data_txn(1'b1, 4'hF, 32'(32'h104 + 4 * k), $urandom, k < 5);
      end
      do_fetch(32'h48, 1'b0, lat);
    join
    check("starve_len", 32'(grant_log.size()), 32'd7);
    for (int k = 0; k < 7 && k < grant_log.size(); k++)
      check($sformatf("starve_order%0d", k), 32'(grant_log[k]), 32'(exp_order[k]));

    // Kill during a slow fetch
    fixed_delay = 3;
    d0 = done_cnt;
    @(posedge clk);
    #1;
    i_addr = 32'h80;
    i_req  = 1'b1;
    @(posedge clk);
    #1;
    check("kill_granted", 32'(m_req), 32'd1);
    i_req  = 1'b0;
    i_kill = 1'b1;
    @(posedge clk);
    #1;
    i_kill = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    check("kill_mem_done", 32'(done_cnt), 32'(d0 + 1));
    check("kill_i_rdata", i_rdata, last_fetch);
    fixed_delay = 0;
    do_fetch(32'h84, 1'b0, lat);
    check("after_kill_latency", 32'(lat), 32'd2);

    // Randomized concurrent traffic with random ack delays
    fixed_delay = -1;
    fork
      for (int k = 0; k < 25; k++) begin
        repeat ($urandom_range(0, 3)) @(posedge clk);
        #1;
        do_fetch(32'($urandom_range(0, 63)) << 2, 1'b0, lat);
      end
      for (int k = 0; k < 30; k++) begin
        repeat ($urandom_range(0, 3)) @(posedge clk);
        #1;
        data_txn(1'($urandom_range(0, 1)), amps[$urandom_range(0, 4)],
                 32'h100 + (32'($urandom_range(0, 63)) << 2), $urandom, 1'b0);
      end
    join
    fixed_delay = 0;
    repeat (2) @(posedge clk);
    #1;
    check("rand_i_drained", 32'(i_exp.size()), 32'd0);
    check("rand_d_drained", 32'(d_exp.size()), 32'd0);

    // Stale request held through the ready cycle
    g0 = grant_cnt;
    do_fetch(32'h58, 1'b1, lat2);
    repeat (3) @(posedge clk);
    #1;
    check("stale_grants", 32'(grant_cnt), 32'(g0 + 1));

    // Spurious ack while idle
    ack_spur = 1'b1;
    @(posedge clk);
    #1;
    ack_spur = 1'b0;
    check("spur_i_ready", 32'(i_ready), 32'd0);
    check("spur_d_ready", 32'(d_ready), 32'd0);
    check("spur_grants", 32'(grant_cnt), 32'(g0 + 1));

    // Asynchronous reset in DBUSY
    fixed_delay = 10;
    t.we = 1'b1;
    t.amp = 4'hF;
    t.addr = 32'h1F0;
    t.wdata = 32'hCAFE_F00D;
    txn_exp.push_back(t);
    d_we = 1'b1; d_amp = 4'hF; d_addr = 32'h1F0; d_wdata = 32'hCAFE_F00D; d_req = 1'b1;
    @(posedge clk);
    #1;
    check("dbusy_m_req", 32'(m_req), 32'd1);
    d_req = 1'b0;
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("async_m_req", 32'(m_req), 32'd0);
    check("async_m_we", 32'(m_we), 32'd0);
    check("async_d_ready", 32'(d_ready), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("post_rst_d_rdata", d_rdata, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
